// File: rtl/pcre_match_serializer.sv
// pcre_match_serializer
//   Collects per-cycle PCRE engine hit vectors for the current packet and emits
//   each matched rule ID once per packet, one per cycle, lowest bit first.
//   Instances chain through perm_in/perm_out so that a lower-priority neighbour
//   drives the shared ID bus only while this instance is idle.
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   vector    engine hit bits for the current cycle (level or pulse)
//   eop       end-of-packet pulse; clears packet state, counts dropped IDs
//   perm_in   permission from the higher-priority neighbour
//   perm_out  permission to the lower-priority neighbour (combinational)
//   id_valid  id_out carries a rule ID
//   id_ready  downstream accepts id_out
//   id_out    rule ID (BASE + bit index + 1)
//   drop_cnt  saturating count of IDs still pending at eop
module pcre_match_serializer #(
  parameter int WIDTH = 16,
  parameter int ID_W  = 10,
  parameter int BASE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] vector,
  input  logic             eop,
  input  logic             perm_in,
  output logic             perm_out,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [ID_W-1:0]  id_out,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_reported;
  logic             r_id_valid;
  logic [ID_W-1:0]  r_id_out;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [WIDTH-1:0] w_new_hits;
  logic [WIDTH-1:0] w_grant;
  logic [WIDTH-1:0] w_grant_eff;
  logic [ID_W-1:0]  w_idx;
  logic [PC_W-1:0]  w_popcnt;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_drop_next;
  logic             w_load;
  logic             w_found;

  assign w_new_hits = vector & ~r_pending & ~r_reported;
  assign w_load     = perm_in & ~eop & (|r_pending) & (~r_id_valid | id_ready);

  // Lowest set bit of pending: one-hot grant plus its index.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_pending[i] && !w_found) begin
        w_grant[i] = 1'b1;
        w_idx      = ID_W'(i);
        w_found    = 1'b1;
      end
    end
  end

  assign w_grant_eff = w_load ? w_grant : '0;

  always_comb begin
    w_popcnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + PC_W'(r_pending[i]);
    end
  end

  // Sum is one bit wider than either operand so saturation is detected
  // even when a single eop drops more IDs than CNT_W can hold.
  always_comb begin
    w_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_popcnt);
    if (w_sum > SUM_W'({CNT_W{1'b1}})) begin
      w_drop_next = '1;
    end else begin
      w_drop_next = w_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_reported <= '0;
      r_id_valid <= 1'b0;
      r_id_out   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (eop) begin
        r_pending  <= '0;
        r_reported <= '0;
        r_drop_cnt <= w_drop_next;
      end else begin
        r_pending  <= (r_pending & ~w_grant_eff) | w_new_hits;
        r_reported <= r_reported | w_grant_eff;
      end

      // An ID already presented survives eop and is still handed off.
      if (w_load) begin
        r_id_out   <= ID_W'(BASE) + w_idx + ID_W'(1);
        r_id_valid <= 1'b1;
      end else if (r_id_valid && id_ready) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign perm_out = perm_in & ~(|r_pending) & ~r_id_valid;
  assign id_valid = r_id_valid;
  assign id_out   = r_id_out;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pcre_match_serializer.sv
module tb_pcre_match_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rdy;

  // standalone instance
  logic [15:0] vec;
  logic        eop, perm;
  logic        perm_out, valid;
  logic [9:0]  id;
  logic [15:0] drop;

  // chained pair: u_a (BASE 0, CNT_W 2) feeds u_b (BASE 16)
  logic [15:0] va, vb;
  logic        ceop, cperm;
  logic        a_perm_out, a_valid, b_perm_out, b_valid;
  logic [9:0]  a_id, b_id;
  logic [1:0]  a_drop;
  logic [15:0] b_drop;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0] q_main[$];
  logic [9:0] q_chain[$];

  pcre_match_serializer #(.WIDTH(16), .ID_W(10), .BASE(0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .vector(vec), .eop(eop), .perm_in(perm),
    .perm_out(perm_out), .id_valid(valid), .id_ready(rdy), .id_out(id), .drop_cnt(drop));

  pcre_match_serializer #(.WIDTH(16), .ID_W(10), .BASE(0), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .vector(va), .eop(ceop), .perm_in(cperm),
    .perm_out(a_perm_out), .id_valid(a_valid), .id_ready(rdy), .id_out(a_id), .drop_cnt(a_drop));

  pcre_match_serializer #(.WIDTH(16), .ID_W(10), .BASE(16), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .vector(vb), .eop(ceop), .perm_in(a_perm_out),
    .perm_out(b_perm_out), .id_valid(b_valid), .id_ready(rdy), .id_out(b_id), .drop_cnt(b_drop));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake pops the next expected ID.
  always @(negedge clk) begin
    if (rst_n && valid && rdy) begin
      if (q_main.size() == 0) chk("main_unexpected_id", 32'(id), 32'h3FF);
      else chk("main_id", 32'(id), 32'(q_main.pop_front()));
    end
    if (rst_n && a_valid && rdy) begin
      if (q_chain.size() == 0) chk("chain_a_unexpected_id", 32'(a_id), 32'h3FF);
      else chk("chain_a_id", 32'(a_id), 32'(q_chain.pop_front()));
    end
    if (rst_n && b_valid && rdy) begin
      if (q_chain.size() == 0) chk("chain_b_unexpected_id", 32'(b_id), 32'h3FF);
      else chk("chain_b_id", 32'(b_id), 32'(q_chain.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1;
    vec = '0; eop = 1'b0; perm = 1'b1;
    va = '0; vb = '0; ceop = 1'b0; cperm = 1'b1;
    step(2);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_id",    32'(id), 0);
    chk("reset_drop",  32'(drop), 0);
    rst_n = 1'b1;
    step(2);

    // 1: two hits in one cycle -> ID 1 then ID 3
    q_main.push_back(10'd1); q_main.push_back(10'd3);
    vec = 16'h0005; step(1); vec = '0;
    step(3);
    @(negedge clk);
    chk("t1_valid_idle", 32'(valid), 0);
    chk("t1_perm_out",   32'(perm_out), 1);

    // 2: held hit emitted once per packet
    q_main.push_back(10'd2);
    @(posedge clk); #1;
    vec = 16'h0002; step(10); vec = '0;
    step(2);
    eop = 1'b1; step(1); eop = 1'b0;
    chk("t2_drop_a", 32'(drop), 0);
    q_main.push_back(10'd2);
    vec = 16'h0002; step(1); vec = '0;
    step(4);
    eop = 1'b1; step(1); eop = 1'b0;
    chk("t2_drop_b", 32'(drop), 0);

    // 3: backpressure holds id_out stable
    rdy = 1'b0;
    q_main.push_back(10'd1); q_main.push_back(10'd16);
    vec = 16'h8001; step(1); vec = '0;
    step(1);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_id",    32'(id), 1);
      chk("t3_hold_valid", 32'(valid), 1);
      chk("t3_hold_perm",  32'(perm_out), 0);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    step(4);
    eop = 1'b1; step(1); eop = 1'b0;

    // 4: no permission -> everything dropped at eop
    perm = 1'b0;
    vec = 16'h00F0; step(1); vec = '0;
    step(2);
    @(negedge clk);
    chk("t4_perm_out", 32'(perm_out), 0);
    chk("t4_valid",    32'(valid), 0);
    @(posedge clk); #1;
    eop = 1'b1; step(1); eop = 1'b0;
    chk("t4_drop", 32'(drop), 4);
    perm = 1'b1;
    step(3);
    chk("t4_perm_after", 32'(perm_out), 1);

    // 5a: chain priority, ID 1 before ID 17
    q_chain.push_back(10'd1); q_chain.push_back(10'd17);
    va = 16'h0001; vb = 16'h0001; step(1); va = '0; vb = '0;
    step(6);
    chk("t5_b_idle", 32'(b_valid), 0);

    // 5b: saturating 2-bit drop counter
    cperm = 1'b0;
    va = 16'h001F; step(1); va = '0;
    step(1);
    ceop = 1'b1; step(1); ceop = 1'b0;
    chk("t5_drop_sat", 32'(a_drop), 3);
    va = 16'h0001; step(1); va = '0;
    step(1);
    ceop = 1'b1; step(1); ceop = 1'b0;
    chk("t5_drop_sat_hold", 32'(a_drop), 3);
    chk("t5_b_drop", 32'(b_drop), 0);

    // 5c: reset mid-burst
    cperm = 1'b1;
    q_chain.push_back(10'd1);
    va = 16'h00FF; step(2);
    @(negedge clk);
    chk("t5_burst_valid", 32'(a_valid), 1);
    #1;
    rst_n = 1'b0; va = '0; cperm = 1'b0;
    #1;
    chk("t5_rst_a_valid", 32'(a_valid), 0);
    chk("t5_rst_a_id",    32'(a_id), 0);
    chk("t5_rst_a_drop",  32'(a_drop), 0);
    chk("t5_rst_a_perm",  32'(a_perm_out), 0);
    chk("t5_rst_b_valid", 32'(b_valid), 0);
    chk("t5_rst_b_id",    32'(b_id), 0);
    chk("t5_rst_b_perm",  32'(b_perm_out), 0);
    chk("t5_rst_main_drop", 32'(drop), 0);
    step(1);
    rst_n = 1'b1;
    step(5);

    chk("q_main_drained",  32'(q_main.size()), 0);
    chk("q_chain_drained", 32'(q_chain.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
